// File: rtl/iitb_pkg.sv
// rtl/iitb_pkg.sv - shared widths, IF/ID packet layout and fetch FSM states
package iitb_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PKT_W   = 41;

  localparam int unsigned PKT_INSTR_HI = 40;
  localparam int unsigned PKT_PC_LO    = 9;
  localparam int unsigned PKT_VALID    = 8;

  localparam logic [PKT_W-1:0] PKT_NOP = '0;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  // Low byte of the packet is reserved and always zero.
  function automatic logic [PKT_W-1:0] make_pkt(input logic [INSTR_W-1:0] instr,
                                                input logic [PC_W-1:0]    pc,
                                                input logic               vld);
    logic [PKT_W-1:0] p;
    p = '0;
    p[PKT_INSTR_HI -: INSTR_W] = instr;
    p[PKT_PC_LO +: PC_W]       = pc;
    p[PKT_VALID]               = vld;
    return p;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry {instr, pc} buffer for a response that arrives under stall
module fetch_hold_buf
  import iitb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] wr_instr,
  input  logic [PC_W-1:0]    wr_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic               valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= wr_instr;
      pc    <= wr_pc;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, imem request handshake, stall buffering and redirect squash
module fetch_stage
  import iitb_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [PKT_W-1:0]   instr_out
);

  localparam logic [PC_W-1:0] PC_INC = PC_W'(1);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    drain_addr_q, drain_addr_d;
  logic [PKT_W-1:0]   out_q, out_d;
  logic               req_en_q;
  logic               hold_load, hold_clear;
  logic [INSTR_W-1:0] hold_instr;
  logic [PC_W-1:0]    hold_pc;
  logic               hold_valid;
  logic               fire;

  fetch_hold_buf u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hold_load),
    .clear    (hold_clear),
    .wr_instr (imem_rdata),
    .wr_pc    (pc_q),
    .instr    (hold_instr),
    .pc       (hold_pc),
    .valid    (hold_valid)
  );

  // req_en_q keeps imem_req low through reset and the first cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      out_q        <= PKT_NOP;
      req_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      out_q        <= out_d;
      req_en_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    out_d        = out_q;
    hold_load    = 1'b0;
    hold_clear   = 1'b0;
    imem_req     = req_en_q && (state_q != S_HOLD);
    imem_addr    = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    fire         = imem_req && imem_valid;

    if (flush) begin
      out_d        = PKT_NOP;
      hold_clear   = 1'b1;
      pc_d         = redirect_pc;
      drain_addr_d = imem_addr;
      // A request still waiting for its response must be kept up until it lands.
      state_d      = (imem_req && !imem_valid) ? S_DRAIN : S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (fire) begin
            if (stall) begin
              hold_load = 1'b1;
              state_d   = S_HOLD;
            end else begin
              out_d = make_pkt(imem_rdata, pc_q, 1'b1);
              pc_d  = pc_q + PC_INC;
            end
          end else if (!stall) begin
            out_d = PKT_NOP;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            out_d   = make_pkt(hold_instr, hold_pc, hold_valid);
            pc_d    = pc_q + PC_INC;
            state_d = S_FETCH;
          end
        end
        S_DRAIN: begin
          out_d = PKT_NOP;
          if (fire) begin
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign instr_out = out_q;

endmodule
